// File: rtl/adc_sampler_pkg.sv
// rtl/adc_sampler_pkg.sv - shared FSM encoding and default parameters for adc_sampler
package adc_sampler_pkg;

    localparam int DEF_WIDTH      = 10;
    localparam int DEF_FRAME_BITS = 16;
    localparam int DEF_LEAD_BITS  = 4;
    localparam int DEF_SCLK_HALF  = 2;
    localparam int DEF_SAMPLE_DIV = 1000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_QUIET = 2'd3
    } state_e;

endpackage

// File: rtl/adc_sample_timer.sv
// rtl/adc_sample_timer.sv - free-running sample period counter with one-cycle tick
module adc_sample_timer
    import adc_sampler_pkg::*;
#(
    parameter int sample_div = DEF_SAMPLE_DIV
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (sample_div > 1) ? $clog2(sample_div) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(sample_div - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        tick    = (count_q == CNT_LAST);
        count_d = tick ? '0 : count_q + CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/adc_sampler.sv
// rtl/adc_sampler.sv - serial ADC frame reader feeding the fir with one word per sample period
module adc_sampler
    import adc_sampler_pkg::*;
#(
    parameter int width      = DEF_WIDTH,
    parameter int frame_bits = DEF_FRAME_BITS,
    parameter int lead_bits  = DEF_LEAD_BITS,
    parameter int sclk_half  = DEF_SCLK_HALF,
    parameter int sample_div = DEF_SAMPLE_DIV
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             adc_sdo,
    output logic             adc_cs_n,
    output logic             adc_sclk,
    output logic [width-1:0] data_out,
    output logic             calculate,
    output logic             overrun
);

    localparam int PH_W  = $clog2(2 * sclk_half + 1);
    localparam int BIT_W = $clog2(frame_bits + 1);

    localparam logic [PH_W-1:0]  HALF_LAST  = PH_W'(sclk_half - 1);
    localparam logic [PH_W-1:0]  QUIET_LAST = PH_W'(2 * sclk_half - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(frame_bits - 1);
    localparam logic [BIT_W-1:0] DATA_FIRST = BIT_W'(lead_bits);
    localparam logic [BIT_W-1:0] DATA_END   = BIT_W'(lead_bits + width);

    logic tick;

    state_e            state_q, state_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic              hi_q, hi_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [width-1:0]  shreg_q, shreg_d;
    logic [width-1:0]  data_q, data_d;
    logic              calc_q, calc_d;
    logic              ovr_q, ovr_d;
    logic              cs_n_q, cs_n_d;
    logic              sclk_q, sclk_d;

    adc_sample_timer #(
        .sample_div(sample_div)
    ) u_timer (
        .clock(clock),
        .reset(reset),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        hi_d    = hi_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        calc_d  = 1'b0;
        ovr_d   = ovr_q;

        case (state_q)
            ST_IDLE: begin
                ph_d = '0;
                if (tick) begin
                    state_d = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (tick) begin
                    ovr_d = 1'b1;
                end
                if (ph_q == HALF_LAST) begin
                    state_d = ST_SHIFT;
                    ph_d    = '0;
                    hi_d    = 1'b0;
                    bit_d   = '0;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end

            ST_SHIFT: begin
                if (tick) begin
                    ovr_d = 1'b1;
                end
                if (ph_q == HALF_LAST) begin
                    ph_d = '0;
                    if (!hi_q) begin
                        // Last low cycle: the next edge is the SCLK rise, so sample here.
                        hi_d = 1'b1;
                        if (bit_q >= DATA_FIRST && bit_q < DATA_END) begin
                            shreg_d = {shreg_q[width-2:0], adc_sdo};
                        end
                    end else begin
                        hi_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            state_d = ST_QUIET;
                            data_d  = shreg_q;
                            calc_d  = 1'b1;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end

            ST_QUIET: begin
                if (ph_q == QUIET_LAST) begin
                    // A tick landing on the way back to idle is a normal frame start.
                    ph_d    = '0;
                    state_d = tick ? ST_SETUP : ST_IDLE;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                    if (tick) begin
                        ovr_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                ph_d    = '0;
            end
        endcase

        // Pins are registered from the next state so they never glitch on decode.
        cs_n_d = (state_d == ST_IDLE) || (state_d == ST_QUIET);
        sclk_d = !((state_d == ST_SHIFT) && !hi_d);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ph_q    <= '0;
            hi_q    <= 1'b0;
            bit_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            calc_q  <= 1'b0;
            ovr_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            hi_q    <= hi_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            calc_q  <= calc_d;
            ovr_q   <= ovr_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
        end
    end

    assign adc_cs_n  = cs_n_q;
    assign adc_sclk  = sclk_q;
    assign data_out  = data_q;
    assign calculate = calc_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_adc_sampler.sv
// tb/tb_adc_sampler.sv - scoreboard bench for adc_sampler over three parameter sets
module tb_adc_sampler;

    localparam int NI    = 3;
    localparam int W     = 10;
    localparam int FB    = 16;
    localparam int LB    = 4;
    localparam int TRAIL = FB - LB - W;

    // Instance 0: defaults; 1: sample_div below the legal minimum; 2: fastest SCLK at minimum sample_div.
    function automatic int half_of(input int k);
        return (k == 2) ? 1 : 2;
    endfunction

    function automatic int div_of(input int k);
        case (k)
            0:       return 1000;
            1:       return 60;
            default: return 35;
        endcase
    endfunction

    function automatic int min_div(input int k);
        return (2 * FB + 3) * half_of(k);
    endfunction

    // A frame needs min_div cycles from its tick before another tick can be accepted.
    function automatic int exp_period(input int k);
        int d;
        d = div_of(k);
        return d * ((min_div(k) + d - 1) / d);
    endfunction

    function automatic int unsigned make_frame(input int unsigned data);
        int unsigned lead;
        int unsigned trail;
        lead  = $urandom_range((1 << LB) - 1, 0);
        trail = $urandom_range((1 << TRAIL) - 1, 0);
        return (lead << (W + TRAIL)) | ((data & ((1 << W) - 1)) << TRAIL) | trail;
    endfunction

    function automatic int unsigned frame_for(input int k, input int n);
        if (k == 0 && n == 0) return 32'h0000_0F14;
        if (k == 0 && n == 1) return make_frame(32'h000);
        if (k == 0 && n == 2) return make_frame(32'h3FF);
        if (k == 2 && n == 0) return make_frame(32'h155);
        return make_frame($urandom);
    endfunction

    function automatic int unsigned data_of(input int unsigned frame);
        return (frame >> TRAIL) & ((1 << W) - 1);
    endfunction

    typedef struct {
        int unsigned data;
        longint      due;
    } exp_t;

    logic          clk = 1'b0;
    logic [NI-1:0] rst;
    logic [NI-1:0] cs_n;
    logic [NI-1:0] sclk;
    logic [NI-1:0] calc;
    logic [NI-1:0] ovr;
    logic [W-1:0]  dout [NI];
    longint        cyc = 0;
    int            checks = 0;
    int            passed = 0;
    int            viol = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input longint act, input longint req);
        checks++;
        if (act == req) begin
            passed++;
        end else begin
            $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h) at cycle %0d",
                     nm, act, act, req, req, cyc);
        end
    endtask

    task automatic flag(input string nm);
        viol++;
        if (viol <= 10) begin
            $display("FAIL %s: protocol rule broken at cycle %0d (violations %0d, required 0)",
                     nm, cyc, viol);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int H = half_of(g);
        localparam int D = div_of(g);

        logic        sdo_r;
        exp_t        exp_q [$];
        exp_t        e;
        int          idx = 0;
        int          strobes = 0;
        int          nframe = 0;
        int unsigned frame_v = 0;
        int unsigned last_data = 0;
        longint      rel = 0;
        longint      last_strobe = -1;
        logic        first, prev_cs, prev_sclk, prev_calc, ovr_seen;

        adc_sampler #(
            .width     (W),
            .frame_bits(FB),
            .lead_bits (LB),
            .sclk_half (H),
            .sample_div(D)
        ) u_dut (
            .clock    (clk),
            .reset    (rst[g]),
            .adc_sdo  (sdo_r),
            .adc_cs_n (cs_n[g]),
            .adc_sclk (sclk[g]),
            .data_out (dout[g]),
            .calculate(calc[g]),
            .overrun  (ovr[g])
        );

        always begin
            @(posedge clk);
            #3;
            if (rst[g]) begin
                exp_q.delete();
                idx         = 0;
                sdo_r       = 1'($urandom);
                first       = 1'b1;
                rel         = cyc;
                last_data   = 0;
                last_strobe = -1;
                prev_cs     = 1'b1;
                prev_sclk   = 1'b1;
                prev_calc   = 1'b0;
                ovr_seen    = 1'b0;
            end else begin
                // ADC model: new bit after each SCLK fall, junk after each rise and while deselected.
                if (prev_cs && !cs_n[g]) begin
                    frame_v = frame_for(g, nframe);
                    nframe++;
                    idx    = 0;
                    e.data = data_of(frame_v);
                    e.due  = cyc + longint'((2 * FB + 1) * H);
                    exp_q.push_back(e);
                    if (first) begin
                        check($sformatf("first_tick_after_reset_%0d", g), cyc - rel, longint'(D));
                        first = 1'b0;
                    end
                end
                if (!cs_n[g] && prev_sclk && !sclk[g] && idx < FB) begin
                    sdo_r = frame_v[FB - 1 - idx];
                    idx++;
                end else if (cs_n[g] || (!prev_sclk && sclk[g])) begin
                    sdo_r = 1'($urandom);
                end

                // Monitor
                if (calc[g]) begin
                    strobes++;
                    if (exp_q.size() == 0) begin
                        check($sformatf("calc_without_frame_%0d", g), longint'(calc[g]), 0);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("data_%0d", g), longint'(dout[g]), longint'(e.data));
                        check($sformatf("latency_%0d", g), cyc, e.due);
                    end
                    if (last_strobe >= 0) begin
                        check($sformatf("period_%0d", g), cyc - last_strobe, longint'(exp_period(g)));
                    end
                    last_strobe = cyc;
                    last_data   = int'(dout[g]);
                end else if (int'(dout[g]) != last_data) begin
                    flag($sformatf("data_out_changed_without_calculate_%0d", g));
                end
                if (prev_calc && calc[g]) flag($sformatf("calculate_longer_than_one_cycle_%0d", g));
                if (cs_n[g] && !sclk[g]) flag($sformatf("sclk_low_while_deselected_%0d", g));
                if (ovr_seen && !ovr[g]) flag($sformatf("overrun_cleared_%0d", g));
                ovr_seen  = ovr_seen | ovr[g];
                prev_cs   = cs_n[g];
                prev_sclk = sclk[g];
                prev_calc = calc[g];
            end
        end
    end

    initial begin
        rst = '1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("reset_cs_n_%0d", k), longint'(cs_n[k]), 1);
            check($sformatf("reset_sclk_%0d", k), longint'(sclk[k]), 1);
            check($sformatf("reset_data_out_%0d", k), longint'(dout[k]), 0);
            check($sformatf("reset_calculate_%0d", k), longint'(calc[k]), 0);
            check($sformatf("reset_overrun_%0d", k), longint'(ovr[k]), 0);
        end
        rst = '0;

        for (int n = 0; n < 6000 && g_dut[0].strobes < 4; n++) @(negedge clk);
        check("frames_before_reset_pulse", longint'(g_dut[0].strobes >= 4), 1);

        for (int n = 0; n < 2000 && !(g_dut[0].idx == 8 && !cs_n[0]); n++) @(negedge clk);
        check("reached_shift_bit7", longint'(g_dut[0].idx), 8);
        rst[0] = 1'b1;
        @(negedge clk);
        check("abort_cs_n", longint'(cs_n[0]), 1);
        check("abort_sclk", longint'(sclk[0]), 1);
        check("abort_calculate", longint'(calc[0]), 0);
        check("abort_data_out", longint'(dout[0]), 0);
        rst[0] = 1'b0;

        for (int n = 0; n < 3000 && g_dut[0].strobes < 6; n++) @(negedge clk);
        check("frames_after_reset_pulse", longint'(g_dut[0].strobes >= 6), 1);

        for (int k = 0; k < NI; k++) begin
            check($sformatf("final_overrun_%0d", k), longint'(ovr[k]), longint'(div_of(k) < min_div(k)));
        end
        check("strobes_inst1", longint'(g_dut[1].strobes > 20), 1);
        check("strobes_inst2", longint'(g_dut[2].strobes > 100), 1);
        check("protocol_violations", longint'(viol), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
